// File: rtl/ans_pkg.sv
// Shared definitions for the ANS codec output path.
//   SYM_WIDTH / BYTE_WIDTH : codec symbol and packed byte widths
//   pack_state_t           : nibble packer state (EVEN: nothing held, ODD: high nibble held)
//   fifo_entry_t           : byte FIFO entry layout {last, pad, data}
package ans_pkg;

    localparam int unsigned SYM_WIDTH  = 4;
    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pack_state_t;

    typedef struct packed {
        logic                  last;
        logic                  pad;
        logic [BYTE_WIDTH-1:0] data;
    } fifo_entry_t;

    localparam int unsigned ENTRY_WIDTH = $bits(fifo_entry_t);

endpackage

// File: rtl/ans_byte_fifo.sv
// Small synchronous FIFO for packed bytes.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push/push_data : write request (ignored while full)
//   pop            : read request (ignored while empty)
//   set_tail_last  : sets the MSB (last flag) of the most recently written entry
//   head           : oldest entry, all zeros when empty
//   empty/full     : occupancy flags
//   count          : number of stored entries
module ans_byte_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 10,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             set_tail_last,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    tail_idx;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign tail_idx = wr_ptr[AW-1:0] - 1'b1;
    assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
        if (set_tail_last && !empty) mem[tail_idx][WIDTH-1] <= 1'b1;
    end

endmodule

// File: rtl/ans_packer.sv
// Packs the codec's 4-bit output stream into bytes (first nibble high) and
// queues them for a byte-wide consumer. A flush closes the stream: a held
// half byte is zero-padded, and the final byte is tagged last.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   nib_in, nib_vld, nib_rdy     : nibble input handshake
//   flush                        : one-cycle end-of-stream request
//   byte_out, byte_vld, byte_rdy : byte output handshake (byte_out 0 when empty)
//   byte_last, byte_pad          : head byte ends a stream / low nibble is padding
//   flush_done                   : one-cycle pulse after a flush is serviced
//   byte_cnt                     : bytes popped since reset, wrapping
module ans_packer
    import ans_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SYM_WIDTH-1:0]  nib_in,
    input  logic                  nib_vld,
    output logic                  nib_rdy,
    input  logic                  flush,
    output logic [BYTE_WIDTH-1:0] byte_out,
    output logic                  byte_vld,
    input  logic                  byte_rdy,
    output logic                  byte_last,
    output logic                  byte_pad,
    output logic                  flush_done,
    output logic [15:0]           byte_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    pack_state_t          state_q, state_d;
    logic [SYM_WIDTH-1:0] hi_q, hi_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 flush_done_q;
    logic [15:0]          byte_cnt_q;

    logic                 nib_acc;
    logic                 pop;
    logic                 push;
    fifo_entry_t          push_entry;
    fifo_entry_t          head_entry;
    logic                 set_tail;
    logic                 svc;
    logic                 empty;
    logic                 full;
    logic [AW:0]          count;

    ans_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push),
        .push_data     (push_entry),
        .pop           (pop),
        .set_tail_last (set_tail),
        .head          (head_entry),
        .empty         (empty),
        .full          (full),
        .count         (count)
    );

    assign nib_rdy    = !flush_pend_q && (state_q == EVEN || !full);
    assign nib_acc    = nib_vld && nib_rdy;
    assign byte_vld   = !empty;
    assign pop        = byte_vld && byte_rdy;
    assign byte_out   = head_entry.data;
    assign byte_last  = head_entry.last;
    assign byte_pad   = head_entry.pad;
    assign flush_done = flush_done_q;
    assign byte_cnt   = byte_cnt_q;

    // nib_acc and flush service never coincide: nib_rdy is low while a flush is pending.
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        push       = 1'b0;
        push_entry = '0;
        set_tail   = 1'b0;
        svc        = 1'b0;
        case (state_q)
            EVEN: begin
                if (nib_acc) begin
                    hi_d    = nib_in;
                    state_d = ODD;
                end else if (flush_pend_q && !(count == (AW+1)'(1) && pop)) begin
                    // Tail entry about to be popped: retry next cycle instead of
                    // tagging a byte that is already leaving.
                    svc      = 1'b1;
                    set_tail = (count != '0);
                end
            end
            ODD: begin
                if (nib_acc) begin
                    push       = 1'b1;
                    push_entry = '{last: 1'b0, pad: 1'b0, data: {hi_q, nib_in}};
                    state_d    = EVEN;
                end else if (flush_pend_q && !full) begin
                    push       = 1'b1;
                    push_entry = '{last: 1'b1, pad: 1'b1, data: {hi_q, 4'h0}};
                    svc        = 1'b1;
                    state_d    = EVEN;
                end
            end
            default: state_d = EVEN;
        endcase
        // Pulses arriving while a flush is already pending are absorbed.
        flush_pend_d = flush_pend_q ? !svc : flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EVEN;
            hi_q         <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= svc;
            if (pop) byte_cnt_q <= byte_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_ans_packer.sv
module tb_ans_packer;

    logic       clk;
    logic       rst_n;
    logic [3:0] nib_in;
    logic       nib_vld;
    logic       nib_rdy;
    logic       flush;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       byte_rdy;
    logic       byte_last;
    logic       byte_pad;
    logic       flush_done;
    logic [15:0] byte_cnt;

    ans_packer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nib_in     (nib_in),
        .nib_vld    (nib_vld),
        .nib_rdy    (nib_rdy),
        .flush      (flush),
        .byte_out   (byte_out),
        .byte_vld   (byte_vld),
        .byte_rdy   (byte_rdy),
        .byte_last  (byte_last),
        .byte_pad   (byte_pad),
        .flush_done (flush_done),
        .byte_cnt   (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned fd_cnt   = 0;

    // Scoreboard entries are {last, pad, byte}.
    logic [9:0] exp_q [$];
    logic       have_hi = 1'b0;
    logic [3:0] hi      = 4'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    // Inputs change 1 time unit after the falling edge.
    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] v);
        bit ok = 0;
        nib_in  = v;
        nib_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (nib_rdy) begin
                ok = 1;
                break;
            end
            cycle();
        end
        if (!ok) check("nib_accept_timeout", 0, 1);
        cycle();
        nib_vld = 1'b0;
        if (have_hi) begin
            exp_q.push_back({2'b00, hi, v});
            have_hi = 1'b0;
        end else begin
            hi      = v;
            have_hi = 1'b1;
        end
    endtask

    // Assumes the FIFO is not full in ODD, so service is immediate.
    task automatic do_flush();
        logic [9:0] e;
        if (have_hi) begin
            exp_q.push_back({2'b11, hi, 4'h0});
            have_hi = 1'b0;
        end else if (exp_q.size() > 0) begin
            e    = exp_q.pop_back();
            e[9] = 1'b1;
            exp_q.push_back(e);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_done_n1", flush_done, 0);
        cycle();
        check("flush_done_n2", flush_done, 1);
    endtask

    task automatic drain();
        byte_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !byte_vld) break;
            cycle();
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_vld", byte_vld, 0);
    endtask

    // Output monitor: samples after the driver has settled the inputs.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (flush_done) fd_cnt++;
                if (byte_vld && byte_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("pop_sb_size", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {byte_last, byte_pad, byte_out}, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned fd0;
        rst_n    = 1'b0;
        nib_in   = 4'h0;
        nib_vld  = 1'b0;
        flush    = 1'b0;
        byte_rdy = 1'b0;
        repeat (2) cycle();
        check("rst_nib_rdy",    nib_rdy, 1);
        check("rst_byte_vld",   byte_vld, 0);
        check("rst_byte_out",   byte_out, 0);
        check("rst_byte_last",  byte_last, 0);
        check("rst_byte_pad",   byte_pad, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_byte_cnt",   byte_cnt, 0);
        rst_n = 1'b1;
        cycle();

        // A,B,C,D streaming
        byte_rdy = 1'b1;
        send_nib(4'hA);
        send_nib(4'hB);
        check("lat_byte_vld", byte_vld, 1);
        check("lat_byte_out", byte_out, 8'hAB);
        send_nib(4'hC);
        send_nib(4'hD);
        drain();
        check("cnt_after_abcd", byte_cnt, 2);

        // A,B,C + flush -> padded last byte
        fd0 = fd_cnt;
        send_nib(4'hA);
        send_nib(4'hB);
        send_nib(4'hC);
        do_flush();
        check("pad_byte_out",  byte_out, 8'hC0);
        drain();
        repeat (3) cycle();
        check("flush_pulses_odd", fd_cnt, fd0 + 1);

        // Fill FIFO with 8 nibbles, 9th held, ODD stall
        byte_rdy = 1'b0;
        for (int i = 1; i <= 9; i++) send_nib(4'(i));
        check("full_nib_rdy", nib_rdy, 0);
        check("full_head",    byte_out, 8'h12);
        check("full_sb_size", exp_q.size(), 4);
        byte_rdy = 1'b1;
        cycle();
        check("unstall_nib_rdy", nib_rdy, 1);
        send_nib(4'h0);
        drain();
        check("cnt_after_full", byte_cnt, 9);

        // Flush in EVEN tags the queued tail byte
        byte_rdy = 1'b0;
        fd0 = fd_cnt;
        send_nib(4'hA);
        send_nib(4'hB);
        do_flush();
        check("even_last", byte_last, 1);
        check("even_pad",  byte_pad, 0);
        drain();
        check("flush_pulses_even", fd_cnt, fd0 + 1);

        // Flush with empty FIFO: no byte, one pulse
        fd0 = fd_cnt;
        do_flush();
        check("empty_flush_vld", byte_vld, 0);
        repeat (3) cycle();
        check("empty_flush_vld_late", byte_vld, 0);
        check("flush_pulses_empty", fd_cnt, fd0 + 1);

        // Mid-stream reset: 3 bytes queued plus a held nibble
        byte_rdy = 1'b0;
        for (int i = 1; i <= 7; i++) send_nib(4'(i));
        check("pre_rst_sb_size", exp_q.size(), 3);
        check("pre_rst_vld", byte_vld, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_nib_rdy",    nib_rdy, 1);
        check("mrst_byte_vld",   byte_vld, 0);
        check("mrst_byte_out",   byte_out, 0);
        check("mrst_byte_last",  byte_last, 0);
        check("mrst_byte_pad",   byte_pad, 0);
        check("mrst_flush_done", flush_done, 0);
        check("mrst_byte_cnt",   byte_cnt, 0);
        exp_q.delete();
        have_hi = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        byte_rdy = 1'b1;
        send_nib(4'hA);
        send_nib(4'hB);
        drain();
        check("cnt_after_rst", byte_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
